keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner_pkg.sv | 40 ++++
 rtl/sync_2ff.sv | 29 ++
 rtl/keypad_scanner.sv | 148 ++++++++++++++
 tb/tb_keypad_scanner.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encodings, idle levels
// and small decode helpers used by the scanner top.
package keypad_scanner_pkg;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESS    = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  localparam logic [3:0] ROWS_IDLE       = 4'b1111;
  localparam logic [3:0] COL_DRIVE_RESET = 4'b1110;

  // Lowest-numbered active-low row wins when several keys share a column.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0]) begin
      idx = 2'd0;
    end else if (!rows[1]) begin
      idx = 2'd1;
    end else if (!rows[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  function automatic logic [3:0] col_onehot_n(input logic [1:0] idx);
    logic [3:0] drive;
    case (idx)
      2'd0:    drive = 4'b1110;
      2'd1:    drive = 4'b1101;
      2'd2:    drive = 4'b1011;
      2'd3:    drive = 4'b0111;
      default: drive = 4'b1110;
    endcase
    return drive;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to a
// configurable idle value so the consumer sees "inactive" out of reset.
module sync_2ff #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] IDLE  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= IDLE;
      sync_r <= IDLE;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front-end: column scan, press/release debounce and a single
// button_pressed strobe per physical press with held row/col indices.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic       button_pressed,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic       key_down
);

  localparam logic [CNT_WIDTH-1:0] SCAN_LAST = CNT_WIDTH'(SCAN_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [3:0]           row_s;
  logic [1:0]           state_r,    state_s;
  logic [1:0]           col_idx_r,  col_idx_s;
  logic [CNT_WIDTH-1:0] cnt_r,      cnt_s;
  logic [1:0]           cand_row_r, cand_row_s;
  logic [1:0]           cand_col_r, cand_col_s;
  logic [3:0]           col_drive_r;
  logic                 button_pressed_r, press_s;
  logic [1:0]           row_r,      row_idx_s;
  logic [1:0]           col_r,      col_out_s;
  logic                 key_down_r, key_down_s;
  logic                 cand_high_s;

  sync_2ff #(
    .WIDTH (4),
    .IDLE  (ROWS_IDLE)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (row_in),
    .q     (row_s)
  );

  assign cand_high_s = row_s[cand_row_r];

  // Next-state and output decode for the scan/debounce FSM.
  always_comb begin
    state_s    = state_r;
    col_idx_s  = col_idx_r;
    cnt_s      = cnt_r;
    cand_row_s = cand_row_r;
    cand_col_s = cand_col_r;
    row_idx_s  = row_r;
    col_out_s  = col_r;
    key_down_s = key_down_r;
    press_s    = 1'b0;
    case (state_r)
      ST_SCAN: begin
        if (cnt_r == SCAN_LAST) begin
          cnt_s = CNT_ZERO;
          if (row_s == ROWS_IDLE) begin
            col_idx_s = col_idx_r + 2'd1;
          end else begin
            cand_row_s = lowest_low(row_s);
            cand_col_s = col_idx_r;
            state_s    = ST_DEBOUNCE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DEBOUNCE: begin
        if (cand_high_s) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_SCAN;
        end else if (cnt_r == DB_LAST) begin
          cnt_s      = CNT_ZERO;
          state_s    = ST_PRESS;
          row_idx_s  = cand_row_r;
          col_out_s  = cand_col_r;
          press_s    = 1'b1;
          key_down_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_PRESS: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_HOLD;
      end
      ST_HOLD: begin
        // Only the accepted key is watched; any low sample restarts the release count.
        if (!cand_high_s) begin
          cnt_s = CNT_ZERO;
        end else if (cnt_r == DB_LAST) begin
          cnt_s      = CNT_ZERO;
          key_down_s = 1'b0;
          col_idx_s  = col_idx_r + 2'd1;
          state_s    = ST_SCAN;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_SCAN;
      end
    endcase
  end

  // State and registered outputs; col_drive follows the column index on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r          <= ST_SCAN;
      col_idx_r        <= 2'd0;
      cnt_r            <= CNT_ZERO;
      cand_row_r       <= 2'd0;
      cand_col_r       <= 2'd0;
      col_drive_r      <= COL_DRIVE_RESET;
      button_pressed_r <= 1'b0;
      row_r            <= 2'd0;
      col_r            <= 2'd0;
      key_down_r       <= 1'b0;
    end else begin
      state_r          <= state_s;
      col_idx_r        <= col_idx_s;
      cnt_r            <= cnt_s;
      cand_row_r       <= cand_row_s;
      cand_col_r       <= cand_col_s;
      col_drive_r      <= col_onehot_n(col_idx_s);
      button_pressed_r <= press_s;
      row_r            <= row_idx_s;
      col_r            <= col_out_s;
      key_down_r       <= key_down_s;
    end
  end

  assign col_drive      = col_drive_r;
  assign button_pressed = button_pressed_r;
  assign row            = row_r;
  assign col            = col_r;
  assign key_down       = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a behavioural keypad matrix drives
// row_in from the column drive; expectations come from the scan/debounce rules.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 8;
  localparam int REL_LAT  = DB + 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic       button_pressed;
  logic [1:0] row;
  logic [1:0] col;
  logic       key_down;

  logic pressed [4][4];

  int checks     = 0;
  int failures   = 0;
  int strobe_cnt = 0;
  int strobe_row = 0;
  int strobe_col = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DB),
    .CNT_WIDTH       (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .row_in         (row_in),
    .col_drive      (col_drive),
    .button_pressed (button_pressed),
    .row            (row),
    .col            (col),
    .key_down       (key_down)
  );

  // Keypad matrix: a closed switch pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c] == 1'b1 && col_drive[c] == 1'b0) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (button_pressed == 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_row <= int'(row);
      strobe_col <= int'(col);
    end
  end

  function automatic logic [3:0] drive_of(input int c);
    logic [3:0] one;
    one = 4'b0001 << c;
    return ~one;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic wait_col(input int c, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (n < 40 && !ok) begin
      tick(1);
      n++;
      if (col_drive == drive_of(c)) ok = 1'b1;
    end
  endtask

  task automatic wait_key_up(output int lat);
    lat = 0;
    while (key_down !== 1'b0 && lat < 60) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    checks++;
    if (col_drive !== 4'b1110) begin
      failures++; $display("FAIL reset_col_drive: got %b expected 1110", col_drive);
    end
    checks++;
    if ({button_pressed, key_down, row, col} !== 6'b000000) begin
      failures++; $display("FAIL reset_outputs: got strobe=%b key_down=%b row=%0d col=%0d expected all 0",
                           button_pressed, key_down, row, col);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp;
    reset = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      exp = drive_of((i / SCAN_DIV) % 4);
      checks++;
      if (col_drive !== exp) begin
        failures++; $display("FAIL idle_scan[%0d]: col_drive=%b expected %b", i, col_drive, exp);
      end
      checks++;
      if ({button_pressed, key_down, row, col} !== 6'b000000) begin
        failures++; $display("FAIL idle_outputs[%0d]: strobe=%b key_down=%b row=%0d col=%0d expected 0",
                             i, button_pressed, key_down, row, col);
      end
    end
  endtask

  task automatic test_single_press();
    int base;
    int lat;
    base = strobe_cnt;
    pressed[2][1] = 1'b1;
    tick(60);
    checks++;
    if (strobe_cnt - base != 1) begin
      failures++; $display("FAIL single_strobes: got %0d expected 1", strobe_cnt - base);
    end
    checks++;
    if (strobe_row != 2 || strobe_col != 1) begin
      failures++; $display("FAIL single_key: got row=%0d col=%0d expected row=2 col=1", strobe_row, strobe_col);
    end
    checks++;
    if (row !== 2'd2 || col !== 2'd1) begin
      failures++; $display("FAIL single_hold_index: got row=%0d col=%0d expected 2/1", row, col);
    end
    checks++;
    if (key_down !== 1'b1) begin
      failures++; $display("FAIL single_key_down: got %b expected 1", key_down);
    end
    pressed[2][1] = 1'b0;
    wait_key_up(lat);
    checks++;
    if (lat != REL_LAT) begin
      failures++; $display("FAIL single_release_latency: got %0d expected %0d", lat, REL_LAT);
    end
    checks++;
    if (col_drive !== 4'b1011) begin
      failures++; $display("FAIL single_resume_col: got %b expected 1011", col_drive);
    end
  endtask

  task automatic test_glitch();
    bit ok;
    int base;
    wait_col(3, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL glitch_reach_col3: got timeout expected col_drive 0111");
    end
    base = strobe_cnt;
    pressed[0][3] = 1'b1;
    tick(3);
    pressed[0][3] = 1'b0;
    wait_col(0, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL glitch_resume_col0: got timeout expected col_drive 1110");
    end
    checks++;
    if (strobe_cnt != base || key_down !== 1'b0) begin
      failures++; $display("FAIL glitch_no_strobe: got strobes=%0d key_down=%b expected 0/0",
                           strobe_cnt - base, key_down);
    end
  endtask

  task automatic test_two_keys();
    int base;
    int lat;
    base = strobe_cnt;
    pressed[1][0] = 1'b1;
    pressed[3][0] = 1'b1;
    tick(50);
    checks++;
    if (strobe_cnt - base != 1 || strobe_row != 1 || strobe_col != 0) begin
      failures++; $display("FAIL two_keys: got strobes=%0d row=%0d col=%0d expected 1 row=1 col=0",
                           strobe_cnt - base, strobe_row, strobe_col);
    end
    clear_keys();
    wait_key_up(lat);
    checks++;
    if (lat != REL_LAT) begin
      failures++; $display("FAIL two_keys_release: got %0d expected %0d", lat, REL_LAT);
    end
  endtask

  task automatic test_hold_rollover();
    int base;
    int lat;
    base = strobe_cnt;
    pressed[3][2] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (i == 100) pressed[0][0] = 1'b1;
      if (i == 150) pressed[0][0] = 1'b0;
    end
    checks++;
    if (key_down !== 1'b1 || row !== 2'd3 || col !== 2'd2) begin
      failures++; $display("FAIL hold_state: got key_down=%b row=%0d col=%0d expected 1 3 2", key_down, row, col);
    end
    repeat (3) begin
      pressed[3][2] = 1'b0;
      tick(3);
      pressed[3][2] = 1'b1;
      tick(2);
    end
    pressed[3][2] = 1'b0;
    wait_key_up(lat);
    checks++;
    if (lat != REL_LAT) begin
      failures++; $display("FAIL hold_bounce_release: got %0d expected %0d", lat, REL_LAT);
    end
    tick(40);
    checks++;
    if (strobe_cnt - base != 1 || strobe_row != 3 || strobe_col != 2) begin
      failures++; $display("FAIL hold_single_strobe: got strobes=%0d row=%0d col=%0d expected 1 row=3 col=2",
                           strobe_cnt - base, strobe_row, strobe_col);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int n;
    wait_col(1, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL rst_reach_col1: got timeout expected col_drive 1101");
    end
    base = strobe_cnt;
    pressed[1][1] = 1'b1;
    // Column settled at the edge just seen; 9 edges later the debounce count is 5.
    tick(9);
    reset = 1'b0;
    #1;
    checks++;
    if (col_drive !== 4'b1110 || key_down !== 1'b0 || button_pressed !== 1'b0) begin
      failures++; $display("FAIL rst_mid_debounce: got col_drive=%b key_down=%b strobe=%b expected 1110 0 0",
                           col_drive, key_down, button_pressed);
    end
    clear_keys();
    tick(2);
    reset = 1'b1;
    tick(40);
    checks++;
    if (strobe_cnt != base) begin
      failures++; $display("FAIL rst_no_strobe: got %0d strobes expected 0", strobe_cnt - base);
    end
    pressed[1][1] = 1'b1;
    n = 0;
    while (strobe_cnt == base && n < 60) begin
      tick(1);
      n++;
    end
    tick(5);
    checks++;
    if (strobe_cnt - base != 1 || key_down !== 1'b1) begin
      failures++; $display("FAIL rst_hold_setup: got strobes=%0d key_down=%b expected 1/1", strobe_cnt - base, key_down);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (key_down !== 1'b0 || col_drive !== 4'b1110) begin
      failures++; $display("FAIL rst_mid_hold: got key_down=%b col_drive=%b expected 0 1110", key_down, col_drive);
    end
    clear_keys();
    tick(2);
    reset = 1'b1;
    tick(30);
    checks++;
    if (strobe_cnt - base != 1 || key_down !== 1'b0) begin
      failures++; $display("FAIL rst_after_hold: got strobes=%0d key_down=%b expected 1/0", strobe_cnt - base, key_down);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int r;
      int c;
      int base;
      int len;
      int lat;
      bit glitch;
      r      = $urandom_range(3, 0);
      c      = $urandom_range(3, 0);
      glitch = 1'($urandom_range(1, 0));
      base   = strobe_cnt;
      if (glitch) begin
        len = $urandom_range(DB - 3, 1);
        pressed[r][c] = 1'b1;
        tick(len);
        pressed[r][c] = 1'b0;
        tick(30);
        checks++;
        if (strobe_cnt != base || key_down !== 1'b0) begin
          failures++; $display("FAIL rand_glitch[%0d] key %0d,%0d len %0d: got strobes=%0d key_down=%b expected 0/0",
                               it, r, c, len, strobe_cnt - base, key_down);
        end
      end else begin
        len = $urandom_range(70, 40);
        pressed[r][c] = 1'b1;
        tick(len);
        checks++;
        if (strobe_cnt - base != 1 || strobe_row != r || strobe_col != c || key_down !== 1'b1) begin
          failures++; $display("FAIL rand_press[%0d]: got strobes=%0d row=%0d col=%0d key_down=%b expected 1 row=%0d col=%0d 1",
                               it, strobe_cnt - base, strobe_row, strobe_col, key_down, r, c);
        end
        pressed[r][c] = 1'b0;
        wait_key_up(lat);
        checks++;
        if (lat != REL_LAT) begin
          failures++; $display("FAIL rand_release[%0d]: got %0d expected %0d", it, lat, REL_LAT);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_keys();
    test_reset();
    test_idle_scan();
    test_single_press();
    test_glitch();
    test_two_keys();
    test_hold_rollover();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
